// File: rtl/aes_cone_capture.sv
// Packs the single-bit AES cone result LSB-first into bytes and queues them in a 2-entry FIFO.
// Latency: byte_vld rises one cycle after the edge that accepts the eighth bit.
// Backpressure: byte_rdy pops the head; a byte that completes while FULL with no pop is dropped and sets sticky ovf.
// Optional AES_CONE_PARITY_EN adds per-entry even parity and the par_out port.
module aes_cone_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic       cone_in,
    input  logic       cone_vld,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    input  logic       byte_rdy,
    output logic [2:0] bit_cnt,
    output logic       ovf
`ifdef AES_CONE_PARITY_EN
    ,
    output logic       par_out
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [1:0] occ_q,   occ_d;
    logic [7:0] head_q,  head_d;
    logic [7:0] tail_q,  tail_d;
    logic       ovf_q,   ovf_d;

    logic       push;
    logic       pop;
    logic [7:0] new_byte;

    // Bits enter at the top and walk down, so after seven shifts bit 0 sits at [0].
    assign push     = cone_vld && (cnt_q == 3'd7);
    assign new_byte = {cone_in, shift_q};
    assign pop      = (occ_q != EMPTY) && byte_rdy;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (cone_vld) begin
            shift_d = {cone_in, shift_q[6:1]};
            cnt_d   = cnt_q + 3'd1;
        end
    end

`ifdef AES_CONE_PARITY_EN
    logic head_par_q, head_par_d;
    logic tail_par_q, tail_par_d;
    logic new_par;

    assign new_par = ^new_byte;
`endif

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        ovf_d  = ovf_q;
`ifdef AES_CONE_PARITY_EN
        head_par_d = head_par_q;
        tail_par_d = tail_par_q;
`endif
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_d = new_byte;
`ifdef AES_CONE_PARITY_EN
                    head_par_d = new_par;
`endif
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_byte;
`ifdef AES_CONE_PARITY_EN
                    head_par_d = new_par;
`endif
                end else if (push) begin
                    tail_d = new_byte;
`ifdef AES_CONE_PARITY_EN
                    tail_par_d = new_par;
`endif
                    occ_d  = FULL;
                end else if (pop) begin
                    occ_d  = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
`ifdef AES_CONE_PARITY_EN
                    head_par_d = tail_par_q;
`endif
                    if (push) begin
                        tail_d = new_byte;
`ifdef AES_CONE_PARITY_EN
                        tail_par_d = new_par;
`endif
                    end else begin
                        occ_d = ONE;
                    end
                end else if (push) begin
                    // No slot frees this cycle: the new byte is lost, queue untouched.
                    ovf_d = 1'b1;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 7'd0;
            cnt_q   <= 3'd0;
            occ_q   <= EMPTY;
            head_q  <= 8'h00;
            tail_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef AES_CONE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            head_par_q <= 1'b0;
            tail_par_q <= 1'b0;
        end else begin
            head_par_q <= head_par_d;
            tail_par_q <= tail_par_d;
        end
    end

    assign par_out = byte_vld ? head_par_q : 1'b0;
`endif

    assign byte_vld = (occ_q != EMPTY);
    assign byte_out = byte_vld ? head_q : 8'h00;
    assign bit_cnt  = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_aes_cone_capture.sv
// Self-checking bench for aes_cone_capture: directed byte scenarios plus randomized traffic
// against a queue-based reference model compared on every cycle.
module tb_aes_cone_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cone_in = 1'b0;
    logic       cone_vld = 1'b0;
    logic       byte_rdy = 1'b0;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic [2:0] bit_cnt;
    logic       ovf;
    logic       par_out;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_cone_capture dut (
        .clk      (clk),
        .rst      (rst),
        .cone_in  (cone_in),
        .cone_vld (cone_vld),
        .byte_out (byte_out),
        .byte_vld (byte_vld),
        .byte_rdy (byte_rdy),
        .bit_cnt  (bit_cnt),
        .ovf      (ovf)
`ifdef AES_CONE_PARITY_EN
        ,
        .par_out  (par_out)
`endif
    );

`ifndef AES_CONE_PARITY_EN
    assign par_out = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a list of accepted bits folded into a byte, and a bounded queue.
    logic [7:0] m_q[$];
    int         m_cnt = 0;
    logic [7:0] m_acc = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_done;
    bit         m_pop;
    logic [7:0] m_fin;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_acc = 8'h00;
            m_ovf = 1'b0;
        end else begin
            m_done = 1'b0;
            m_pop  = (m_q.size() > 0) && byte_rdy;
            if (cone_vld) begin
                m_acc[m_cnt] = cone_in;
                m_cnt++;
                if (m_cnt == 8) begin
                    m_done = 1'b1;
                    m_fin  = m_acc;
                    m_cnt  = 0;
                    m_acc  = 8'h00;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_done) begin
                if (m_q.size() < 2) m_q.push_back(m_fin);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_vld", {31'd0, byte_vld}, {31'd0, m_q.size() > 0});
            chk("bit_cnt", {29'd0, bit_cnt}, m_cnt);
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
            if (m_q.size() > 0) begin
                chk("byte_out", {24'd0, byte_out}, {24'd0, m_q[0]});
`ifdef AES_CONE_PARITY_EN
                chk("par_out", {31'd0, par_out}, {31'd0, ^m_q[0]});
`endif
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic b, input logic rd);
        @(negedge clk);
        rst      = r;
        cone_vld = v;
        cone_in  = b;
        byte_rdy = rd;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic rd, input bit gap);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, d[i], rd);
            if (gap && i < 7) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), rd);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdy_pct;

        // Reset state and the basic 8'h4D byte (bits 1,0,1,1,0,0,1,0).
        do_reset();
        chk("rst_byte_out", {24'd0, byte_out}, 32'h00);
        chk("rst_byte_vld", {31'd0, byte_vld}, 32'd0);
        chk("rst_bit_cnt", {29'd0, bit_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        send_byte(8'h4D, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_vld", {31'd0, byte_vld}, 32'd1);
        chk("basic_byte", {24'd0, byte_out}, 32'h4D);
`ifdef AES_CONE_PARITY_EN
        chk("basic_par", {31'd0, par_out}, 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Same bits with idle cycles between them.
        send_byte(8'h4D, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_byte", {24'd0, byte_out}, 32'h4D);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: A5, 3C queued, FF dropped.
        do_reset();
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_head", {24'd0, byte_out}, 32'hA5);
        chk("bp_ovf", {31'd0, ovf}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_head_a5", {24'd0, byte_out}, 32'hA5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_head_3c", {24'd0, byte_out}, 32'h3C);
        chk("bp_ovf_sticky", {31'd0, ovf}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_empty", {31'd0, byte_vld}, 32'd0);
        chk("bp_ovf_held", {31'd0, ovf}, 32'd1);

        // Push and pop together while FULL.
        do_reset();
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, (i == 0), 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pp_head", {24'd0, byte_out}, 32'h3C);
        chk("pp_ovf", {31'd0, ovf}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pp_tail", {24'd0, byte_out}, 32'h01);

        // Reset after 5 accepted bits; a bit offered with rst is ignored.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_cnt", {29'd0, bit_cnt}, 32'd0);
        send_byte(8'h80, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_byte", {24'd0, byte_out}, 32'h80);

        // Randomized traffic with varying consumer pressure and sporadic resets.
        rdy_pct = 50;
        for (int c = 0; c < 6000; c++) begin
            if (c % 300 == 0) rdy_pct = $urandom_range(0, 100);
            drive(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 99) < 75),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < rdy_pct));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/aes_cone_capture.md
AES_CONE_CAPTURE -- requirements
Module: aes_cone_capture

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: cone_in  input  1  single-bit result of the upstream AES timing cone, the n_35-class output.
REQ-004 SHALL have port: cone_vld  input  1  cone_in is valid this cycle.
REQ-005 SHALL have port: byte_out  output  8  assembled byte at head of output queue.
REQ-006 SHALL have port: byte_vld  output  1  byte_out is valid.
REQ-007 SHALL have port: byte_rdy  input  1  consumer accepts byte_out this cycle.
REQ-008 SHALL have port: bit_cnt  output  3  number of bits held in the partial byte, 0..7.
REQ-009 SHALL have port: ovf  output  1  sticky overflow; a completed byte was dropped.
REQ-010 SHALL have port: par_out  output  1  even parity of byte_out; present only with AES_CONE_PARITY_EN.

Function
REQ-011 SHALL sample cone_in on every clk edge where cone_vld=1 and ignore it otherwise.
REQ-012 SHALL shift sampled bits LSB-first: the first accepted bit is byte bit 0 and the eighth accepted bit is bit 7.
REQ-013 SHALL increment bit_cnt per accepted bit and wrap it 7->0 on the eighth bit, which completes the byte.
REQ-014 SHALL hold completed bytes in a 2-entry FIFO; occupancy states are EMPTY (0), ONE (1) and FULL (2).
REQ-015 SHALL drive byte_vld=1 whenever the FIFO is not EMPTY, with byte_out equal to the oldest entry.
REQ-016 SHALL pop the head entry on a cycle where byte_vld=1 and byte_rdy=1.
REQ-017 SHALL have a latency of one cycle: byte_vld rises on the cycle after the edge that accepted the eighth bit, when the FIFO was EMPTY.
REQ-018 SHALL apply the following state transitions, where push means the byte completes this cycle:
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: ONE->EMPTY, FULL->ONE.
  - push and pop together: state unchanged, order preserved.
REQ-019 SHALL, on push while FULL with byte_rdy=1, accept the new byte, because a pop in the same cycle frees a slot.
REQ-020 SHALL, on push while FULL with byte_rdy=0, discard the new byte, leave the FIFO contents unchanged and set ovf=1.
REQ-021 SHALL hold ovf at 1 until rst and no other condition clears it.
REQ-022 SHALL ignore byte_rdy while byte_vld=0, with no state change.
REQ-023 SHALL hold byte_out stable while byte_vld=1 and byte_rdy=0.
REQ-024 SHALL reset the partial-byte shift register and bit_cnt only at rst and never on overflow, so that bit alignment is preserved after a drop.

Reset
REQ-025 SHALL, on a clk edge with rst=1, set bit_cnt=0, the partial byte to 0, FIFO=EMPTY, byte_vld=0, byte_out=8'h00, ovf=0, and par_out=0 when present.
REQ-026 SHALL give rst priority over cone_vld and byte_rdy in the same cycle; a bit presented during reset is not captured.
REQ-027 SHALL discard a partially assembled byte and all queued bytes when rst asserts mid-operation.

Configuration
REQ-028 SHALL, when AES_CONE_PARITY_EN is defined, store a parity bit with each FIFO entry and drive par_out = XOR of byte_out bits [7:0], valid only while byte_vld=1.
REQ-029 SHALL, when AES_CONE_PARITY_EN is undefined, omit the par_out port and the parity storage entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover a basic byte: after rst, drive cone_vld=1 with bits 1,0,1,1,0,0,1,0 on consecutive cycles and byte_rdy=1 -> byte_vld=1 one cycle after the eighth bit, with byte_out=8'h4D and par_out=0.
REQ-031 SHALL cover gaps in valid: the same 8 bits with cone_vld=0 inserted between each -> byte_out=8'h4D, and bit_cnt never advances on gap cycles.
REQ-032 SHALL cover backpressure: byte_rdy=0 while streaming bytes 8'hA5, 8'h3C, 8'hFF -> FIFO holds A5,3C, FF is dropped, ovf=1; then byte_rdy=1 -> outputs A5 then 3C, and ovf stays 1.
REQ-033 SHALL cover push and pop while FULL: FIFO FULL (A5,3C) with byte_rdy=1 on the cycle byte 8'h01 completes -> A5 is popped, 01 is enqueued, ovf=0.
REQ-034 SHALL cover reset mid-byte: rst=1 after 5 accepted bits, then 8 bits forming 8'h80 -> bit_cnt=0 after rst and byte_out=8'h80, with no residue from the earlier 5 bits.
